pcm_frame_fifo: RTL and testbench

- Sits directly downstream of the PDM CIC decimator and consumes its `pcm_out`/`pcm_valid` single-cycle sample strobe.
- Buffers decimated PCM samples in a first-word-fall-through FIFO.
- Presents samples on a valid/ready stream with frame-boundary tags (`out_first`/`out_last`) for DMA or feature-extraction consumers.
- Reports fill level and counts samples dropped on overflow.

---
 rtl/pcm_frame_fifo_if.sv | 23 ++
 rtl/pcm_frame_fifo.sv | 90 +++++++++
 tb/tb_pcm_frame_fifo.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_frame_fifo_if.sv
// Sample-in strobe and tagged sample-out stream between decimator, frame FIFO and consumer.
// The slave modport is the FIFO's view; the master modport is the producer/consumer side.
interface pcm_frame_fifo_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] pcm_in;
  logic                     pcm_in_valid;
  logic        [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_first;
  logic                     out_last;

  modport master (
    output pcm_in, pcm_in_valid, out_ready,
    input  out_data, out_valid, out_first, out_last
  );

  modport slave (
    input  pcm_in, pcm_in_valid, out_ready,
    output out_data, out_valid, out_first, out_last
  );
endinterface

// File: rtl/pcm_frame_fifo.sv
// FWFT FIFO for decimated PCM with frame first/last tags, fill level and overflow accounting.
// Latency: one edge from strobe to head; when full, new samples drop unless a pop happens on the same edge.
module pcm_frame_fifo #(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64,
  parameter int DATA_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pcm_frame_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     clear_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FRAME_LEN);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_POS = PW'(FRAME_LEN - 1);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              first;
    logic              last;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [PW-1:0] pos;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  ent_t          head;

  assign empty = (count == '0);
  assign pop   = !empty && bus.out_ready;
  // A full FIFO still takes the sample when the head leaves on the same edge.
  assign push  = bus.pcm_in_valid && ((count != FULL) || pop);
  assign drop  = bus.pcm_in_valid && !push;

  assign head          = empty ? '0 : mem[rd_ptr];
  assign bus.out_data  = head.dat;
  assign bus.out_first = head.first;
  assign bus.out_last  = head.last;
  assign bus.out_valid = !empty;
  assign level         = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dat: bus.pcm_in, first: (pos == '0), last: (pos == LAST_POS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pos        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      // Position follows sample time, so dropped samples still advance it.
      if (bus.pcm_in_valid) begin
        pos <= (pos == LAST_POS) ? '0 : pos + PW'(1);
      end

      if (drop) begin
        overflow <= 1'b1;
        if (clear_ovf)                drop_count <= 8'd1;
        else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (clear_ovf) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pcm_frame_fifo.sv
// Scoreboard bench for pcm_frame_fifo with DEPTH=16, FRAME_LEN=4.
module tb_pcm_frame_fifo;
  localparam int DEPTH = 16;
  localparam int FL    = 4;

  typedef struct packed {
    logic [15:0] d;
    logic        f;
    logic        l;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic       clear_ovf;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;

  pcm_frame_fifo_if #(.DATA_W(16)) bus ();

  pcm_frame_fifo #(.DEPTH(DEPTH), .FRAME_LEN(FL), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clear_ovf  (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp;
  int   n_err;
  ent_t q[$];
  int   mcount;
  int   mpos;
  int   mdrops;
  logic movf;
  int   seen_first;
  int   seen_last;

  task automatic model_reset();
    q.delete();
    mcount = 0;
    mpos   = 0;
    mdrops = 0;
    movf   = 1'b0;
  endtask

  task automatic do_reset();
    bus.pcm_in_valid = 1'b0;
    bus.out_ready    = 1'b0;
    bus.pcm_in       = '0;
    clear_ovf        = 1'b0;
    rst_n            = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, update the model, score any pop, then check registered state.
  task automatic step(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
    logic pop;
    logic push;
    logic drop;
    ent_t e;
    bus.pcm_in_valid = v;
    bus.pcm_in       = d;
    bus.out_ready    = rdy;
    clear_ovf        = clr;
    #1;
    n_cmp++;
    if (bus.out_valid !== (mcount != 0)) begin
      n_err++;
      $display("FAIL out_valid_pre: got %0b expected %0b", bus.out_valid, (mcount != 0));
    end
    pop = (mcount != 0) && rdy;
    if (pop) begin
      e = q.pop_front();
      n_cmp++;
      if (bus.out_data !== e.d || bus.out_first !== e.f || bus.out_last !== e.l) begin
        n_err++;
        $display("FAIL pop_head: got %h/%0b/%0b expected %h/%0b/%0b",
                 bus.out_data, bus.out_first, bus.out_last, e.d, e.f, e.l);
      end
      if (e.f) seen_first++;
      if (e.l) seen_last++;
      mcount--;
    end
    push = v && ((mcount + (pop ? 1 : 0)) < DEPTH || pop);
    drop = v && !push;
    if (push) begin
      q.push_back('{d: d, f: (mpos == 0), l: (mpos == FL - 1)});
      mcount++;
    end
    if (drop) begin
      movf   = 1'b1;
      mdrops = clr ? 1 : (mdrops < 255 ? mdrops + 1 : 255);
    end else if (clr) begin
      movf   = 1'b0;
      mdrops = 0;
    end
    if (v) mpos = (mpos + 1) % FL;
    @(posedge clk);
    #1;
    n_cmp++;
    if (level !== 5'(mcount) || overflow !== movf || drop_count !== 8'(mdrops)) begin
      n_err++;
      $display("FAIL post_state: got lvl=%0d ovf=%0b drops=%0d expected lvl=%0d ovf=%0b drops=%0d",
               level, overflow, drop_count, mcount, movf, mdrops);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 || drop_count !== 8'd0 ||
        bus.out_data !== 16'h0 || bus.out_first !== 1'b0 || bus.out_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b lvl=%0d ovf=%0b drops=%0d d=%h f=%0b l=%0b expected all zero",
               bus.out_valid, level, overflow, drop_count, bus.out_data, bus.out_first, bus.out_last);
    end
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    n_cmp++;
    if (level !== 5'd3 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001 ||
        bus.out_first !== 1'b1 || bus.out_last !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL three_samples: got lvl=%0d v=%0b d=%h f=%0b l=%0b ovf=%0b expected 3/1/0001/1/0/0",
               level, bus.out_valid, bus.out_data, bus.out_first, bus.out_last, overflow);
    end
    drain(4);
  endtask

  task automatic test_frame_tags();
    do_reset();
    seen_first = 0;
    seen_last  = 0;
    for (int i = 0; i < 9; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    drain(2);
    n_cmp++;
    if (seen_first != 3 || seen_last != 2 || q.size() != 0) begin
      n_err++;
      $display("FAIL frame_tags: got firsts=%0d lasts=%0d left=%0d expected 3/2/0",
               seen_first, seen_last, q.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    n_cmp++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd4) begin
      n_err++;
      $display("FAIL overflow: got lvl=%0d ovf=%0b drops=%0d expected 16/1/4", level, overflow, drop_count);
    end
    drain(17);
    n_cmp++;
    if (level !== 5'd0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_drain: got lvl=%0d v=%0b expected 0/0", level, bus.out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'h100 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    n_cmp++;
    if (level !== 5'd16 || drop_count !== 8'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_push_pop: got lvl=%0d drops=%0d ovf=%0b expected 16/0/0", level, drop_count, overflow);
    end
    drain(17);
  endtask

  task automatic test_saturate_clear();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    n_cmp++;
    if (drop_count !== 8'd255 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: got drops=%0d ovf=%0b expected 255/1", drop_count, overflow);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1);
    n_cmp++;
    if (drop_count !== 8'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ovf: got drops=%0d ovf=%0b expected 0/0", drop_count, overflow);
    end
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    n_cmp++;
    if (drop_count !== 8'd1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clear_vs_drop: got drops=%0d ovf=%0b expected 1/1", drop_count, overflow);
    end
    drain(17);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 16'h50 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h60 + 16'(i), 1'b0, 1'b0);
    bus.pcm_in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (level !== 5'd0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got lvl=%0d v=%0b expected 0/0", level, bus.out_valid);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    n_cmp++;
    if (bus.out_first !== 1'b1 || bus.out_data !== 16'h1234 || level !== 5'd1) begin
      n_err++;
      $display("FAIL first_after_reset: got f=%0b d=%h lvl=%0d expected 1/1234/1",
               bus.out_first, bus.out_data, level);
    end
    drain(2);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    seen_first = 0;
    seen_last  = 0;
    rst_n      = 1'b0;
    clear_ovf  = 1'b0;
    bus.pcm_in       = '0;
    bus.pcm_in_valid = 1'b0;
    bus.out_ready    = 1'b0;
    #12;
    test_reset();
    test_frame_tags();
    test_overflow();
    test_full_push_pop();
    test_saturate_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
